// File: rtl/alu_checker_pkg.sv
// alu_checker_pkg: opcodes, FSM states and LFSR step shared by the ALU checker
package alu_checker_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction
  function automatic logic [1:0] op_for(input logic [1:0] phase);
    return phase == 2'd0 ? OP_ADD : phase == 2'd1 ? OP_SUB : OP_AND;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with same-cycle push/pop and synchronous flush
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    do_pop = pop && !empty && !clr;
    do_push = push && !clr && (!full || do_pop);
    dout = mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/alu_checker.sv
// alu_checker: on-chip stimulus generator and in-order result checker for a pipelined ALU
module alu_checker
  import alu_checker_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          TESTS   = 32,
  parameter int          DEPTH   = 4,
  parameter int          OP_MODE = 0,
  parameter int          PATTERN = 0,
  parameter logic [31:0] SEED    = 32'h1,
  localparam int         CW      = $clog2(TESTS + 2)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_alu_ready,
  input  logic             i_alu_res_valid,
  input  logic [WIDTH-1:0] i_alu_result,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [CW-1:0]    o_pass_cnt,
  output logic [CW-1:0]    o_fail_cnt,
  output logic             o_err,
  output logic [CW-1:0]    o_first_fail_idx
);
  localparam int EW = CW + WIDTH;
  localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [CW-1:0] LAST = CW'(TESTS - 1);
  localparam logic [WIDTH-1:0] B0 = WIDTH'(TESTS - 1);
  state_t state, state_nxt;
  logic [31:0] lfsr_a, lfsr_b, lfsr_a_nxt, lfsr_b_nxt;
  logic [CW-1:0] t, t_inc, res_idx;
  logic [1:0] phase, phase_nxt, op_r;
  logic [WIDTH-1:0] a_r, b_r, exp_val, res_exp;
  logic [EW-1:0] head;
  logic start, pop, issue, hit, miss, full, empty;
  always_comb begin
    start = i_start && (state == ST_IDLE || state == ST_DONE);
    pop = i_alu_res_valid && !empty;
    o_alu_valid = (state == ST_RUN) && (!full || pop);
    issue = o_alu_valid && i_alu_ready;
    res_idx = head[EW-1:WIDTH];
    res_exp = head[WIDTH-1:0];
    hit = pop && (res_exp == i_alu_result);
    miss = i_alu_res_valid && !hit;
    t_inc = t + 1'b1;
    lfsr_a_nxt = lfsr_step(lfsr_a);
    lfsr_b_nxt = lfsr_step(lfsr_b);
    phase_nxt = (OP_MODE == 0 || phase == 2'd2) ? 2'd0 : phase + 2'd1;
    exp_val = op_r == OP_ADD ? a_r + b_r : op_r == OP_SUB ? a_r - b_r : a_r & b_r;
    o_alu_a = a_r;
    o_alu_b = b_r;
    o_alu_op = o_alu_valid ? op_r : OP_NOP;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = start ? ST_RUN :
                (issue && t == LAST) ? ST_DRAIN :
                (state == ST_DRAIN && empty && !i_alu_res_valid) ? ST_DONE : state;
  always_comb begin
    o_busy = state == ST_RUN || state == ST_DRAIN;
    o_done = state == ST_DONE;
  end
  // Operand registers always hold the transaction currently on offer.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      lfsr_a <= '0;
      lfsr_b <= '0;
      t <= '0;
      phase <= '0;
      a_r <= '0;
      b_r <= '0;
      op_r <= OP_NOP;
    end else if (start) begin
      lfsr_a <= SEED_NZ;
      lfsr_b <= ~SEED_NZ;
      t <= '0;
      phase <= '0;
      a_r <= PATTERN != 0 ? '0 : SEED_NZ[WIDTH-1:0];
      b_r <= PATTERN != 0 ? B0 : ~SEED_NZ[WIDTH-1:0];
      op_r <= OP_ADD;
    end else if (issue) begin
      lfsr_a <= lfsr_a_nxt;
      lfsr_b <= lfsr_b_nxt;
      t <= t_inc;
      phase <= phase_nxt;
      a_r <= PATTERN != 0 ? WIDTH'(t_inc) : lfsr_a_nxt[WIDTH-1:0];
      b_r <= PATTERN != 0 ? B0 - WIDTH'(t_inc) : lfsr_b_nxt[WIDTH-1:0];
      op_r <= op_for(phase_nxt);
    end
  // An unexpected first error leaves the index all-ones since err blocks later captures.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_pass_cnt <= '0;
      o_fail_cnt <= '0;
      o_err <= 1'b0;
      o_first_fail_idx <= '1;
    end else if (start) begin
      o_pass_cnt <= '0;
      o_fail_cnt <= '0;
      o_err <= 1'b0;
      o_first_fail_idx <= '1;
    end else if (i_alu_res_valid) begin
      if (hit && !(&o_pass_cnt)) o_pass_cnt <= o_pass_cnt + 1'b1;
      if (miss && !(&o_fail_cnt)) o_fail_cnt <= o_fail_cnt + 1'b1;
      if (miss && !o_err) o_first_fail_idx <= pop ? res_idx : '1;
      if (miss) o_err <= 1'b1;
    end
  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .clr(start),
    .push(issue),
    .pop(pop),
    .din({t, exp_val}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_alu_checker.sv
// tb_alu_checker: randomized run of alu_checker against a latency ALU model and a behavioural scoreboard
module tb_alu_checker;
  localparam int W = 16;
  localparam int N = 20;
  localparam int D = 4;
  localparam int LAT = 5;
  localparam int CW = $clog2(N + 2);
  localparam int SAT = (1 << CW) - 1;
  localparam int WM = (1 << W) - 1;
  localparam logic [31:0] MASK = 32'h8020_0003;
  localparam logic [31:0] SEED = 32'h1;
  logic clk = 0, rst = 1, start = 0, rdy = 1, alu_rv = 0, spur_rv = 0;
  logic [W-1:0] alu_res = '0;
  logic [W-1:0] a, b;
  logic [1:0] op;
  logic valid, busy, done, err;
  logic [CW-1:0] pass_c, fail_c, idx;
  alu_checker #(.WIDTH(W), .TESTS(N), .DEPTH(D), .OP_MODE(1), .PATTERN(0), .SEED(SEED)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_alu_ready(rdy),
    .i_alu_res_valid(alu_rv | spur_rv), .i_alu_result(alu_res),
    .o_alu_a(a), .o_alu_b(b), .o_alu_op(op), .o_alu_valid(valid),
    .o_busy(busy), .o_done(done), .o_pass_cnt(pass_c), .o_fail_cnt(fail_c),
    .o_err(err), .o_first_fail_idx(idx)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask
  // Behavioural model of the checker
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;
  mst_t ms = M_IDLE;
  int m_t = 0, m_pass = 0, m_fail = 0, m_idx = SAT;
  bit m_err = 0;
  bit [31:0] la = 0, lb = 0;
  int q_exp[$], q_idx[$];
  int run_no = 0;
  logic [31:0] seq [2][N];
  logic [W-1:0] first_a [2], first_b [2];
  logic [1:0] first_op [2];
  function automatic bit [31:0] lstep(bit [31:0] s);
    return (s >> 1) ^ (s[0] ? MASK : 32'h0);
  endfunction
  function automatic int expect_of(int x, int y, int o);
    return o == 1 ? (x + y) & WM : o == 2 ? (x - y) & WM : x & y;
  endfunction
  function automatic int sinc(int v);
    return v == SAT ? v : v + 1;
  endfunction
  logic [W-1:0] pa, pb;
  logic [1:0] pop_;
  bit stalled = 0;
  always @(negedge clk) begin
    bit rv, ev, was_empty;
    int ea, eb, eo, e, ix;
    if (rst) begin
      ms = M_IDLE; m_pass = 0; m_fail = 0; m_err = 0; m_idx = SAT;
      q_exp.delete(); q_idx.delete(); stalled = 0;
    end else begin
      rv = alu_rv | spur_rv;
      was_empty = q_exp.size() == 0;
      ev = ms == M_RUN && (q_exp.size() < D || (rv && !was_empty));
      ea = int'(la) & WM;
      eb = int'(lb) & WM;
      eo = m_t % 3 + 1;
      chk("valid", valid, ev);
      chk("busy", busy, ms == M_RUN || ms == M_DRAIN);
      chk("done", done, ms == M_DONE);
      chk("pass_cnt", pass_c, m_pass);
      chk("fail_cnt", fail_c, m_fail);
      chk("err", err, m_err);
      chk("first_idx", idx, m_idx);
      if (ev) begin
        chk("op_a", a, ea);
        chk("op_b", b, eb);
        chk("opcode", op, eo);
        if (run_no < 2 && m_t < 2) begin
          first_a[m_t] = a; first_b[m_t] = b; first_op[m_t] = op;
        end
        if (run_no < 2 && rdy) seq[run_no][m_t] = {a, b};
      end else chk("op_nop", op, 0);
      if (stalled && valid) begin
        chk("stall_a", a, pa);
        chk("stall_b", b, pb);
        chk("stall_op", op, pop_);
      end
      stalled = valid && !rdy; pa = a; pb = b; pop_ = op;
      if (rv) begin
        if (!was_empty) begin
          e = q_exp.pop_front();
          ix = q_idx.pop_front();
          if (e == int'(alu_res)) m_pass = sinc(m_pass);
          else begin
            m_fail = sinc(m_fail);
            if (!m_err) m_idx = ix;
            m_err = 1;
          end
        end else begin
          m_fail = sinc(m_fail);
          m_err = 1;
        end
      end
      if ((ms == M_IDLE || ms == M_DONE) && start) begin
        ms = M_RUN; m_pass = 0; m_fail = 0; m_err = 0; m_idx = SAT;
        q_exp.delete(); q_idx.delete();
        la = SEED; lb = ~SEED; m_t = 0;
      end else if (ev && rdy) begin
        q_exp.push_back(expect_of(ea, eb, eo));
        q_idx.push_back(m_t);
        la = lstep(la); lb = lstep(lb); m_t++;
        if (m_t == N) ms = M_DRAIN;
      end else if (ms == M_DRAIN && was_empty && !rv) ms = M_DONE;
    end
  end
  // ALU model: fixed latency, in-order, optional corruption per transaction index
  typedef struct {int due; logic [W-1:0] r;} alu_t;
  alu_t aq[$];
  int cyc = 0, alu_n = 0;
  bit bad [N];
  bit rand_rdy = 0;
  function automatic logic [W-1:0] alu_f(logic [W-1:0] x, logic [W-1:0] y, logic [1:0] o);
    return o == 2'd1 ? x + y : o == 2'd2 ? x - y : o == 2'd3 ? x & y : '0;
  endfunction
  always @(negedge clk) begin
    alu_t en;
    if (rst) begin
      aq.delete(); alu_n = 0;
    end else begin
      if (start && !busy) alu_n = 0;
      if (valid && rdy) begin
        en.due = cyc + LAT;
        en.r = alu_f(a, b, op) ^ W'(alu_n < N && bad[alu_n]);
        aq.push_back(en);
        alu_n++;
      end
    end
  end
  always @(posedge clk) begin
    #1;
    cyc++;
    rdy = rand_rdy ? 1'($urandom) : 1'b1;
    if (!rst && aq.size() > 0 && aq[0].due <= cyc) begin
      alu_rv = 1; alu_res = aq[0].r; void'(aq.pop_front());
    end else alu_rv = 0;
  end
  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_op"}, op, 0);
    chk({tag, "_a"}, a, 0);
    chk({tag, "_b"}, b, 0);
    chk({tag, "_pass"}, pass_c, 0);
    chk({tag, "_fail"}, fail_c, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_idx"}, idx, SAT);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_reached_done"}, done, 1);
  endtask
  initial begin
    int k, diffs;
    for (int i = 0; i < N; i++) bad[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 0;
    @(posedge clk); #1;
    spur_rv = 1;
    @(posedge clk); #1;
    spur_rv = 0;
    @(posedge clk); #1;
    chk("spur_fail", fail_c, 1);
    chk("spur_err", err, 1);
    chk("spur_idx", idx, SAT);
    chk("spur_idle", busy, 0);
    spur_rv = 1;
    repeat (40) @(posedge clk);
    #1;
    spur_rv = 0;
    @(posedge clk); #1;
    chk("fail_saturated", fail_c, SAT);
    rand_rdy = 1;
    run_no = 0;
    pulse_start();
    repeat (6) @(posedge clk);
    #1;
    pulse_start();
    wait_done("run1");
    chk("run1_pass", pass_c, N);
    chk("run1_fail", fail_c, 0);
    chk("run1_err", err, 0);
    chk("run1_idx", idx, SAT);
    chk("t0_a", first_a[0], 16'h0001);
    chk("t0_b", first_b[0], 16'hFFFE);
    chk("t0_op", first_op[0], 2'b01);
    chk("t1_a", first_a[1], 16'h0003);
    chk("t1_b", first_b[1], 16'hFFFF);
    chk("t1_op", first_op[1], 2'b10);
    run_no = 1;
    bad[5] = 1;
    bad[9] = 1;
    @(posedge clk); #1;
    pulse_start();
    wait_done("run2");
    chk("run2_pass", pass_c, N - 2);
    chk("run2_fail", fail_c, 2);
    chk("run2_err", err, 1);
    chk("run2_idx", idx, 5);
    diffs = 0;
    for (int i = 0; i < N; i++) if (seq[0][i] !== seq[1][i]) diffs++;
    chk("seq_repeat", diffs, 0);
    bad[5] = 0;
    bad[9] = 0;
    run_no = 2;
    @(posedge clk); #1;
    pulse_start();
    k = 0;
    while (!(q_exp.size() == 3 && m_pass >= 2) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("three_outstanding", q_exp.size(), 3);
    #1;
    rst = 1;
    #1;
    check_reset("midrun");
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    pulse_start();
    wait_done("run4");
    chk("run4_pass", pass_c, N);
    chk("run4_fail", fail_c, 0);
    chk("run4_err", err, 0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
